pipe_register: RTL and testbench
================================

Name: pipe_register

Overview:
- Parametrised multi-stage pipeline register with valid/ready handshake on both sides, per-stage bubble collapsing and a synchronous flush.
- Successor to the plain single-stage datapath register: adds depth, backpressure, occupancy reporting and flush.
- Sits between datapath stages, e.g. fetch to decode or execute to writeback, wherever a stallable, flushable boundary is needed.

Parameters:
- DATA_WIDTH, 32, width of the data word.
- STAGES, 2, number of register stages. Legal range 1..16; any other value is an elaboration error.
- RESET_VALUE, 0, value loaded into every stage data register on reset.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block will accept in_data this cycle.
- in_data  input  DATA_WIDTH  producer word.
- out_valid  output  1  stage STAGES-1 holds a valid word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  DATA_WIDTH  stage STAGES-1 data.
- occupancy  output  $clog2(STAGES+1)  count of valid stages.

Behaviour:
- One clock, `clock`. Reset is synchronous and active-high on `reset`; it is sampled only on the rising edge.
- Reset:
  - All stage valid bits go to 0 and all stage data registers go to RESET_VALUE.
  - After reset: out_valid=0, out_data=RESET_VALUE, occupancy=0, in_ready=1.
  - Reset overrides flush and all handshakes.
- Transfers:
  - Input transfer: in_valid && in_ready on a rising edge.
  - Output transfer: out_valid && out_ready on a rising edge.
- Per-stage advance:
  - adv[S-1] = out_ready || !v[S-1].
  - adv[i] = adv[i+1] || !v[i] for i < S-1.
  - in_ready = adv[0] && !flush. This is combinational from out_ready through the chain; no registered ready.
- Stage update when adv[i] is 1:
  - Stage i loads from stage i-1. Stage 0 loads from in_data with valid=in_valid && in_ready.
  - When the previous stage is not valid, only the valid bit is cleared; the data register keeps its old contents (no enable on data).
- Stage hold when adv[i] is 0:
  - The stage holds both data and valid.
  - out_data is stable while out_valid && !out_ready.
- Timing:
  - Latency: a word accepted at edge N appears on out_valid/out_data after edge N+STAGES-1, with no backpressure.
  - Throughput is one word per cycle.
  - Bubbles collapse: an empty stage always accepts from upstream, even while the downstream stage is stalled.
- Flush (flush=1 at an edge):
  - All valid bits clear at that edge.
  - in_ready=0 during the flush cycle, so no input is captured.
  - An output transfer in the same cycle still counts: the consumer owns that word.
  - Data registers are unchanged.
  - Next cycle: occupancy=0, out_valid=0.
- occupancy:
  - Registered popcount of the stage valid bits, updated on the same edge as the valid bits.
  - Range is 0..STAGES.
- Full condition (occupancy==STAGES with out_ready=0):
  - in_ready=0 and all stages hold.
  - If out_ready=1 while full, one word leaves, one word enters and occupancy stays STAGES.
- Empty condition (occupancy==0): out_valid=0 and in_ready=1 (unless flush).
- STAGES=1:
  - Degenerates to a single register with in_ready = (out_ready || !v[0]) && !flush.
  - A word accepted at edge N is visible after edge N.
- Handshake rules for the environment:
  - The producer must hold in_data/in_valid until accepted.
  - The block never drops an accepted word except by flush or reset.
- No X propagation: out_data shows RESET_VALUE until the first word reaches the last stage.

Test Plan:
- Streaming, STAGES=2, DATA_WIDTH=32:
  - Stimulus: reset for 2 cycles, then push 0x11,0x22,0x33 back-to-back with out_ready=1.
  - Required response: out_valid rises 1 cycle after the first accept; outputs 0x11,0x22,0x33 on consecutive cycles; occupancy peaks at 2.
- Backpressure and full:
  - Stimulus: out_ready=0, push 0xA0,0xA1,0xA2.
  - Required response: 0xA0,0xA1 accepted; in_ready=0 with 0xA2 pending; occupancy=2; out_data=0xA0 held.
  - Stimulus: raise out_ready.
  - Required response: outputs in order 0xA0,0xA1,0xA2.
- Bubble collapse:
  - Stimulus: STAGES=4, out_ready=0, push 0x5 alone, then wait 3 cycles, then push 0x6.
  - Required response: 0x5 reaches the last stage; 0x6 is accepted immediately (in_ready=1); occupancy=2.
- Flush:
  - Stimulus: with occupancy=2 and out_valid=1, assert flush for one cycle with in_valid=1 and out_ready=1.
  - Required response: the output word counts as transferred; in_ready=0 in that cycle; the input is not captured; next cycle occupancy=0 and out_valid=0.
- Reset mid-operation:
  - Stimulus: RESET_VALUE=0xDEAD, pipeline full and stalled, assert reset for one edge.
  - Required response: out_valid=0, out_data=0xDEAD, occupancy=0, in_ready=1 next cycle; reset also wins over a simultaneous flush.
- STAGES=1 simultaneous push/pop:
  - Stimulus: holding 0x7 with out_ready=1 and in_valid=1 carrying 0x8.
  - Required response: 0x7 transfers out; 0x8 is captured on the same edge; occupancy stays 1.

Source files
------------

// File: rtl/pipe_register.sv
// pipe_register
//   Multi-stage pipeline register with valid/ready handshakes on both sides,
//   bubble collapsing between stages and a synchronous flush of all valids.
//
// Parameters
//   DATA_WIDTH   width of the data word
//   STAGES       number of register stages (1..16)
//   RESET_VALUE  value loaded into every stage data register on reset
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high reset (wins over flush/handshakes)
//   flush      synchronous clear of every stage valid bit
//   in_valid   producer has a word on in_data
//   in_ready   block accepts in_data this cycle (combinational from out_ready)
//   in_data    producer word
//   out_valid  last stage holds a valid word
//   out_ready  consumer accepts out_data this cycle
//   out_data   last stage data
//   occupancy  registered count of valid stages
module pipe_register #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    STAGES      = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int          OCC_W = $clog2(STAGES + 1);
    localparam int unsigned NS    = STAGES;

    generate
        if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
            $error("pipe_register: STAGES must be in 1..16");
        end
    endgenerate

    logic [STAGES-1:0]     valid;
    logic [DATA_WIDTH-1:0] data [STAGES];
    logic [OCC_W-1:0]      occ;

    logic [STAGES-1:0]     adv;
    logic [STAGES-1:0]     valid_next;
    logic [STAGES-1:0]     load;
    logic [OCC_W-1:0]      occ_next;
    logic                  accept;

    // Advance chain runs from the output back to the input, so an empty stage
    // always accepts even while everything downstream of it is stalled.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = out_ready || !valid[STAGES-1];
        for (int unsigned k = 1; k < NS; k++) begin
            adv[NS-1-k] = adv[NS-k] || !valid[NS-1-k];
        end
    end

    assign in_ready = adv[0] && !flush;
    assign accept   = in_valid && in_ready;

    // Data loads only when a valid word moves in; a bubble clears just the
    // valid bit. Flush suppresses all data movement as well.
    always_comb begin
        valid_next = valid;
        load       = '0;
        if (adv[0]) begin
            valid_next[0] = accept;
            load[0]       = accept;
        end
        for (int unsigned i = 1; i < NS; i++) begin
            if (adv[i]) begin
                valid_next[i] = valid[i-1];
                load[i]       = valid[i-1] && !flush;
            end
        end
        if (flush) begin
            valid_next = '0;
        end
    end

    always_comb begin
        occ_next = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            occ_next = occ_next + OCC_W'(valid_next[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
            occ   <= '0;
            for (int unsigned i = 0; i < NS; i++) begin
                data[i] <= RESET_VALUE;
            end
        end else begin
            valid <= valid_next;
            occ   <= occ_next;
            if (load[0]) begin
                data[0] <= in_data;
            end
            for (int unsigned i = 1; i < NS; i++) begin
                if (load[i]) begin
                    data[i] <= data[i-1];
                end
            end
        end
    end

    assign out_valid = valid[STAGES-1];
    assign out_data  = data[STAGES-1];
    assign occupancy = occ;

endmodule

// File: tb/tb_pipe_register.sv
// tb_pipe_register
//   Directed bench for pipe_register using three instances:
//   A: STAGES=2, RESET_VALUE=0 (streaming, backpressure, flush)
//   B: STAGES=4, RESET_VALUE=0xDEAD (bubble collapse, reset mid-operation)
//   C: STAGES=1 (simultaneous push/pop)
module tb_pipe_register;

    logic clock;
    int   compared;
    int   mismatched;

    logic        a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;

    logic        b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [2:0]  b_occ;

    logic        c_reset, c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_data, c_out_data;
    logic [0:0]  c_occ;

    pipe_register #(.DATA_WIDTH(32), .STAGES(2), .RESET_VALUE(32'h0)) u_a (
        .clock(clock), .reset(a_reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_register #(.DATA_WIDTH(32), .STAGES(4), .RESET_VALUE(32'hDEAD)) u_b (
        .clock(clock), .reset(b_reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    pipe_register #(.DATA_WIDTH(32), .STAGES(1), .RESET_VALUE(32'h0)) u_c (
        .clock(clock), .reset(c_reset), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .occupancy(c_occ)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 time unit after the rising edge; checks happen after
    // that settles, well away from the next edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        tick(); tick();
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        #1;
        compared++; if (a_out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", a_out_valid); mismatched++; end
        compared++; if (a_out_data !== 32'h0) begin $display("FAIL reset_out_data: got %h want 00000000", a_out_data); mismatched++; end
        compared++; if (a_occ !== 2'd0) begin $display("FAIL reset_occupancy: got %0d want 0", a_occ); mismatched++; end
        compared++; if (a_in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b want 1", a_in_ready); mismatched++; end
        compared++; if (b_out_data !== 32'hDEAD) begin $display("FAIL reset_b_out_data: got %h want 0000dead", b_out_data); mismatched++; end
        compared++; if (c_out_valid !== 1'b0) begin $display("FAIL reset_c_out_valid: got %b want 0", c_out_valid); mismatched++; end
    endtask

    task automatic test_streaming();
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_data = 32'h11;
        #1;
        compared++; if (a_in_ready !== 1'b1) begin $display("FAIL stream_in_ready: got %b want 1", a_in_ready); mismatched++; end
        tick();
        a_in_data = 32'h22;
        compared++; if (a_out_valid !== 1'b0) begin $display("FAIL stream_latency_early: got %b want 0", a_out_valid); mismatched++; end
        compared++; if (a_occ !== 2'd1) begin $display("FAIL stream_occ1: got %0d want 1", a_occ); mismatched++; end
        tick();
        a_in_data = 32'h33;
        compared++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h11) begin $display("FAIL stream_word0: got v=%b d=%h want v=1 d=00000011", a_out_valid, a_out_data); mismatched++; end
        compared++; if (a_occ !== 2'd2) begin $display("FAIL stream_occ_peak: got %0d want 2", a_occ); mismatched++; end
        tick();
        a_in_valid = 1'b0;
        compared++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h22) begin $display("FAIL stream_word1: got v=%b d=%h want v=1 d=00000022", a_out_valid, a_out_data); mismatched++; end
        compared++; if (a_occ !== 2'd2) begin $display("FAIL stream_occ_steady: got %0d want 2", a_occ); mismatched++; end
        tick();
        compared++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h33) begin $display("FAIL stream_word2: got v=%b d=%h want v=1 d=00000033", a_out_valid, a_out_data); mismatched++; end
        compared++; if (a_occ !== 2'd1) begin $display("FAIL stream_occ_drain: got %0d want 1", a_occ); mismatched++; end
        tick();
        compared++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin $display("FAIL stream_empty: got v=%b occ=%0d want v=0 occ=0", a_out_valid, a_occ); mismatched++; end
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'hA0;
        tick();
        a_in_data = 32'hA1;
        #1;
        compared++; if (a_in_ready !== 1'b1) begin $display("FAIL bp_bubble_ready: got %b want 1", a_in_ready); mismatched++; end
        tick();
        a_in_data = 32'hA2;
        #1;
        compared++; if (a_in_ready !== 1'b0) begin $display("FAIL bp_full_ready: got %b want 0", a_in_ready); mismatched++; end
        compared++; if (a_occ !== 2'd2) begin $display("FAIL bp_full_occ: got %0d want 2", a_occ); mismatched++; end
        compared++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hA0) begin $display("FAIL bp_head: got v=%b d=%h want v=1 d=000000a0", a_out_valid, a_out_data); mismatched++; end
        tick();
        compared++; if (a_out_data !== 32'hA0 || a_occ !== 2'd2) begin $display("FAIL bp_hold: got d=%h occ=%0d want d=000000a0 occ=2", a_out_data, a_occ); mismatched++; end
        a_out_ready = 1'b1;
        #1;
        compared++; if (a_in_ready !== 1'b1) begin $display("FAIL bp_full_pass_ready: got %b want 1", a_in_ready); mismatched++; end
        tick();
        a_in_valid = 1'b0;
        compared++; if (a_out_data !== 32'hA1 || a_occ !== 2'd2) begin $display("FAIL bp_out1: got d=%h occ=%0d want d=000000a1 occ=2", a_out_data, a_occ); mismatched++; end
        tick();
        compared++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hA2) begin $display("FAIL bp_out2: got v=%b d=%h want v=1 d=000000a2", a_out_valid, a_out_data); mismatched++; end
        tick();
        compared++; if (a_out_valid !== 1'b0) begin $display("FAIL bp_drained: got %b want 0", a_out_valid); mismatched++; end
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'h55;
        tick();
        a_in_data = 32'h66;
        tick();
        compared++; if (a_occ !== 2'd2 || a_out_valid !== 1'b1) begin $display("FAIL flush_setup: got occ=%0d v=%b want occ=2 v=1", a_occ, a_out_valid); mismatched++; end
        a_flush = 1'b1; a_in_data = 32'h77; a_out_ready = 1'b1;
        #1;
        compared++; if (a_in_ready !== 1'b0) begin $display("FAIL flush_in_ready: got %b want 0", a_in_ready); mismatched++; end
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        compared++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin $display("FAIL flush_cleared: got occ=%0d v=%b want occ=0 v=0", a_occ, a_out_valid); mismatched++; end
        compared++; if (a_out_data !== 32'h55) begin $display("FAIL flush_data_kept: got %h want 00000055", a_out_data); mismatched++; end
        tick(); tick(); tick();
        compared++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin $display("FAIL flush_no_capture: got v=%b occ=%0d want v=0 occ=0", a_out_valid, a_occ); mismatched++; end
    endtask

    task automatic test_bubble_collapse();
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 32'h5;
        tick();
        b_in_valid = 1'b0;
        tick(); tick(); tick();
        compared++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h5) begin $display("FAIL bubble_head: got v=%b d=%h want v=1 d=00000005", b_out_valid, b_out_data); mismatched++; end
        compared++; if (b_occ !== 3'd1) begin $display("FAIL bubble_occ1: got %0d want 1", b_occ); mismatched++; end
        b_in_valid = 1'b1; b_in_data = 32'h6;
        #1;
        compared++; if (b_in_ready !== 1'b1) begin $display("FAIL bubble_ready: got %b want 1", b_in_ready); mismatched++; end
        tick();
        b_in_valid = 1'b0;
        compared++; if (b_occ !== 3'd2) begin $display("FAIL bubble_occ2: got %0d want 2", b_occ); mismatched++; end
        tick(); tick();
        compared++; if (b_out_data !== 32'h5 || b_occ !== 3'd2) begin $display("FAIL bubble_stall_hold: got d=%h occ=%0d want d=00000005 occ=2", b_out_data, b_occ); mismatched++; end
        b_out_ready = 1'b1;
        tick();
        compared++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h6) begin $display("FAIL bubble_next: got v=%b d=%h want v=1 d=00000006", b_out_valid, b_out_data); mismatched++; end
        tick();
        compared++; if (b_out_valid !== 1'b0 || b_occ !== 3'd0) begin $display("FAIL bubble_drained: got v=%b occ=%0d want v=0 occ=0", b_out_valid, b_occ); mismatched++; end
    endtask

    task automatic test_reset_mid();
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            b_in_data = i;
            tick();
        end
        b_in_data = 32'h5;
        #1;
        compared++; if (b_occ !== 3'd4 || b_in_ready !== 1'b0) begin $display("FAIL rmid_full: got occ=%0d rdy=%b want occ=4 rdy=0", b_occ, b_in_ready); mismatched++; end
        compared++; if (b_out_data !== 32'h1) begin $display("FAIL rmid_head: got %h want 00000001", b_out_data); mismatched++; end
        b_reset = 1'b1; b_flush = 1'b1;
        tick();
        b_reset = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0;
        #1;
        compared++; if (b_out_valid !== 1'b0 || b_occ !== 3'd0) begin $display("FAIL rmid_cleared: got v=%b occ=%0d want v=0 occ=0", b_out_valid, b_occ); mismatched++; end
        compared++; if (b_out_data !== 32'hDEAD) begin $display("FAIL rmid_data: got %h want 0000dead", b_out_data); mismatched++; end
        compared++; if (b_in_ready !== 1'b1) begin $display("FAIL rmid_in_ready: got %b want 1", b_in_ready); mismatched++; end
    endtask

    task automatic test_single_stage();
        c_out_ready = 1'b0;
        c_in_valid = 1'b1; c_in_data = 32'h7;
        tick();
        c_in_valid = 1'b0;
        #1;
        compared++; if (c_out_valid !== 1'b1 || c_out_data !== 32'h7 || c_occ !== 1'b1) begin $display("FAIL s1_hold: got v=%b d=%h occ=%0d want v=1 d=00000007 occ=1", c_out_valid, c_out_data, c_occ); mismatched++; end
        compared++; if (c_in_ready !== 1'b0) begin $display("FAIL s1_full_ready: got %b want 0", c_in_ready); mismatched++; end
        c_out_ready = 1'b1; c_in_valid = 1'b1; c_in_data = 32'h8;
        #1;
        compared++; if (c_in_ready !== 1'b1) begin $display("FAIL s1_pass_ready: got %b want 1", c_in_ready); mismatched++; end
        tick();
        c_in_valid = 1'b0;
        compared++; if (c_out_valid !== 1'b1 || c_out_data !== 32'h8 || c_occ !== 1'b1) begin $display("FAIL s1_swap: got v=%b d=%h occ=%0d want v=1 d=00000008 occ=1", c_out_valid, c_out_data, c_occ); mismatched++; end
        tick();
        compared++; if (c_out_valid !== 1'b0 || c_occ !== 1'b0 || c_in_ready !== 1'b1) begin $display("FAIL s1_empty: got v=%b occ=%0d rdy=%b want v=0 occ=0 rdy=1", c_out_valid, c_occ, c_in_ready); mismatched++; end
    endtask

    initial begin
        compared = 0; mismatched = 0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        #2;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble_collapse();
        test_reset_mid();
        test_single_stage();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
